mem_lsu: RTL and testbench

Multi-cycle load/store unit for the MEM stage of the 5-stage RV32 pipeline. It consumes the execute stage's outputs (ALU result as effective address, forwarded rs2 as store data, funct3 as access size) and runs a valid/ready data-bus transaction. It generates byte strobes and sign- or zero-extends load data. It stalls the pipeline until the access completes.

---
 rtl/mem_lsu.sv | 162 ++++++++++++++++
 tb/tb_mem_lsu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a valid/ready data bus and stalling the pipeline.
// Optional feature: define MEM_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.

module mem_lsu #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              stall,
   output logic [XLEN-1:0]   load_data,
   output logic              misaligned_fault,
   output logic              dbus_req_valid,
   input  logic              dbus_req_ready,
   output logic              dbus_we,
   output logic [XLEN-1:0]   dbus_addr,
   output logic [XLEN-1:0]   dbus_wdata,
   output logic [XLEN/8-1:0] dbus_wstrb,
   input  logic              dbus_rsp_valid,
   input  logic [XLEN-1:0]   dbus_rdata
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_REQ  = 2'b01;
   localparam logic [1:0] ST_WAIT = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN/8-1:0] wstrb_q;
   logic              we_q;
   logic [2:0]        funct3_q;

   logic              is_byte;
   logic              is_half;
   logic              access;
   logic              accept;
   logic [XLEN-1:0]   eff_addr;
   logic [XLEN-1:0]   wdata_rep;
   logic [XLEN/8-1:0] wstrb_next;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;
   logic [XLEN-1:0]   load_ext;

   // Size decode: funct3[1:0] picks byte/half, every other code is a word access.
   assign is_byte = (funct3[1:0] == 2'b00);
   assign is_half = (funct3[1:0] == 2'b01);
   assign access  = req_valid && (mem_read || mem_write);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
   logic misaligned;

   assign misaligned = (is_half && addr[0]) ||
                       (!is_byte && !is_half && (addr[1:0] != 2'b00));
   assign eff_addr   = addr;
   assign accept     = (state == ST_IDLE) && access && !misaligned && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         misaligned_fault <= 1'b0;
      end else begin
         misaligned_fault <= (state == ST_IDLE) && access && misaligned;
      end
   end
`else
   // Without trapping, the low address bits are dropped to the access's natural alignment.
   always_comb begin
      eff_addr = addr;
      if (is_half) begin
         eff_addr[0] = 1'b0;
      end else if (!is_byte) begin
         eff_addr[1:0] = 2'b00;
      end
   end

   assign accept           = (state == ST_IDLE) && access && !rst;
   assign misaligned_fault = 1'b0;
`endif

   always_comb begin
      wstrb_next = '0;
      wdata_rep  = '0;
      if (mem_write) begin
         if (is_byte) begin
            wstrb_next = 4'b0001 << eff_addr[1:0];
            wdata_rep  = {4{wdata[7:0]}};
         end else if (is_half) begin
            wstrb_next = eff_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep  = {2{wdata[15:0]}};
         end else begin
            wstrb_next = 4'b1111;
            wdata_rep  = wdata;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept)         state_next = ST_REQ;
         ST_REQ:  if (dbus_req_ready) state_next = ST_WAIT;
         ST_WAIT: if (dbus_rsp_valid) state_next = ST_DONE;
         ST_DONE:                     state_next = ST_IDLE;
         default:                     state_next = ST_IDLE;
      endcase
   end

   // Extraction uses the latched address/size, since the pipeline inputs are not trusted after accept.
   always_comb begin
      case (addr_q[1:0])
         2'b00:   byte_lane = dbus_rdata[7:0];
         2'b01:   byte_lane = dbus_rdata[15:8];
         2'b10:   byte_lane = dbus_rdata[23:16];
         default: byte_lane = dbus_rdata[31:24];
      endcase
      half_lane = addr_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   load_ext = funct3_q[2] ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         2'b01:   load_ext = funct3_q[2] ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: load_ext = dbus_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         we_q      <= 1'b0;
         funct3_q  <= 3'b000;
         load_data <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            addr_q   <= eff_addr;
            wdata_q  <= wdata_rep;
            wstrb_q  <= wstrb_next;
            we_q     <= mem_write;
            funct3_q <= funct3;
         end
         if ((state == ST_WAIT) && dbus_rsp_valid && !we_q) begin
            load_data <= load_ext;
         end
      end
   end

   assign stall          = accept || (state == ST_REQ) || (state == ST_WAIT);
   assign dbus_req_valid = (state == ST_REQ);
   assign dbus_we        = we_q;
   assign dbus_addr      = {addr_q[XLEN-1:2], 2'b00};
   assign dbus_wdata     = wdata_q;
   assign dbus_wstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven bench for mem_lsu plus hand sequences for reset-in-flight and misalignment.
// Misalignment expectations follow MEM_LSU_MISALIGN_TRAP_EN when it is defined.

module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] load_data;
   logic        misaligned_fault;
   logic        dbus_req_valid;
   logic        dbus_req_ready;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_wstrb;
   logic        dbus_rsp_valid;
   logic [31:0] dbus_rdata;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ready_dly;
      int          rsp_dly;
      logic [31:0] exp_addr;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_load;
      int          exp_stall;
   } vec_t;

   vec_t vecs[15];

   int          r_stall;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_we;
   logic [31:0] r_load;
   logic        r_fault;
   logic        r_done;

   mem_lsu #(.XLEN(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .funct3           (funct3),
      .addr             (addr),
      .wdata            (wdata),
      .stall            (stall),
      .load_data        (load_data),
      .misaligned_fault (misaligned_fault),
      .dbus_req_valid   (dbus_req_valid),
      .dbus_req_ready   (dbus_req_ready),
      .dbus_we          (dbus_we),
      .dbus_addr        (dbus_addr),
      .dbus_wdata       (dbus_wdata),
      .dbus_wstrb       (dbus_wstrb),
      .dbus_rsp_valid   (dbus_rsp_valid),
      .dbus_rdata       (dbus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                  input int rdy, input int rsp, input logic [31:0] ea,
                                  input logic [3:0] es, input logic [31:0] ewd,
                                  input logic [31:0] el, input int est);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
      v.ready_dly = rdy; v.rsp_dly = rsp; v.exp_addr = ea; v.exp_wstrb = es;
      v.exp_wdata = ewd; v.exp_load = el; v.exp_stall = est;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Runs one access from an IDLE cycle to the DONE cycle, playing the bus side with the
   // requested ready/response delays and scrambling the pipeline inputs after accept.
   task automatic applyStimulus(input vec_t v);
      int  req_cyc;
      int  wait_cyc;
      bit  seen_req;
      req_cyc   = 0;
      wait_cyc  = 0;
      seen_req  = 0;
      r_stall   = 0;
      r_done    = 1'b0;
      r_fault   = 1'b0;
      r_addr    = '0;
      r_wdata   = '0;
      r_wstrb   = '0;
      r_we      = 1'b0;
      r_load    = '0;
      req_valid  = 1'b1;
      mem_read   = v.rd;
      mem_write  = v.wr;
      funct3     = v.f3;
      addr       = v.addr;
      wdata      = v.wdata;
      dbus_rdata = v.rdata;
      for (int c = 0; c < 40; c++) begin
         dbus_req_ready = 1'b0;
         dbus_rsp_valid = 1'b0;
         if (c == 1) begin
            addr      = ~v.addr;
            wdata     = ~v.wdata;
            funct3    = v.f3 ^ 3'b100;
            mem_read  = v.wr;
            mem_write = v.rd;
         end
         #1;
         r_fault = r_fault | misaligned_fault;
         if (dbus_req_valid) begin
            seen_req = 1;
            r_addr   = dbus_addr;
            r_wdata  = dbus_wdata;
            r_wstrb  = dbus_wstrb;
            r_we     = dbus_we;
            if (req_cyc >= v.ready_dly) dbus_req_ready = 1'b1;
            req_cyc++;
         end else if (seen_req && stall) begin
            if (wait_cyc >= v.rsp_dly) dbus_rsp_valid = 1'b1;
            wait_cyc++;
         end
         if (stall) begin
            r_stall++;
         end else if (seen_req) begin
            r_load = load_data;
            r_done = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      dbus_req_ready = 1'b0;
      dbus_rsp_valid = 1'b0;
      if (r_done) begin
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      rst            = 1'b1;
      req_valid      = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      funct3         = 3'b000;
      addr           = '0;
      wdata          = '0;
      dbus_req_ready = 1'b0;
      dbus_rsp_valid = 1'b0;
      dbus_rdata     = '0;

      //                rd    wr    f3      addr          wdata         rdata       rdy rsp exp_addr     strb     exp_wdata     exp_load    stall
      vecs[0]  = mkVec(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hDEADBEEF, 3);
      vecs[1]  = mkVec(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF0000, 0, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFFFF80, 3);
      vecs[2]  = mkVec(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF0000, 0, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h00000080, 3);
      vecs[3]  = mkVec(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234ABCD, 32'h0,        2, 0, 32'h0000_0200, 4'b1100, 32'hABCDABCD, 32'h00000080, 5);
      vecs[4]  = mkVec(1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h000000A5, 32'h0,        0, 0, 32'h0000_0000, 4'b1000, 32'hA5A5A5A5, 32'h00000080, 3);
      vecs[5]  = mkVec(1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'h0,        32'hBEEF1234, 0, 1, 32'h0000_0004, 4'b0000, 32'h0,        32'h0000BEEF, 4);
      vecs[6]  = mkVec(1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'h0,        32'h8001FFFF, 0, 2, 32'h0000_0004, 4'b0000, 32'h0,        32'hFFFF8001, 5);
      vecs[7]  = mkVec(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFEF00D, 32'h0,        1, 1, 32'h0000_0010, 4'b1111, 32'hCAFEF00D, 32'hFFFF8001, 5);
      vecs[8]  = mkVec(1'b1, 1'b0, 3'b001, 32'h0000_0008, 32'h0,        32'h00007FFE, 0, 0, 32'h0000_0008, 4'b0000, 32'h0,        32'h00007FFE, 3);
      vecs[9]  = mkVec(1'b1, 1'b0, 3'b000, 32'h0000_0009, 32'h0,        32'hAABB12CC, 0, 0, 32'h0000_0008, 4'b0000, 32'h0,        32'h00000012, 3);
      vecs[10] = mkVec(1'b1, 1'b0, 3'b110, 32'h0000_000C, 32'h0,        32'h11223344, 0, 0, 32'h0000_000C, 4'b0000, 32'h0,        32'h11223344, 3);
      vecs[11] = mkVec(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234567F, 32'h0,        0, 0, 32'h0000_0000, 4'b0010, 32'h7F7F7F7F, 32'h11223344, 3);
      vecs[12] = mkVec(1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 0, 32'h0000_0020, 4'b1111, 32'h0F0F0F0F, 32'h11223344, 3);
      vecs[13] = mkVec(1'b0, 1'b1, 3'b001, 32'h0000_0200, 32'h0000BEEF, 32'h0,        0, 1, 32'h0000_0200, 4'b0011, 32'hBEEFBEEF, 32'h11223344, 4);
      vecs[14] = mkVec(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h007F0000, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000007F, 4);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset stall",     {31'b0, stall},            32'h0);
      checkOutput("reset load_data", load_data,                 32'h0);
      checkOutput("reset fault",     {31'b0, misaligned_fault}, 32'h0);
      checkOutput("reset req_valid", {31'b0, dbus_req_valid},   32'h0);
      checkOutput("reset we",        {31'b0, dbus_we},          32'h0);
      checkOutput("reset addr",      dbus_addr,                 32'h0);
      checkOutput("reset wdata",     dbus_wdata,                32'h0);
      checkOutput("reset wstrb",     {28'b0, dbus_wstrb},       32'h0);

      // Consecutive vectors start in the IDLE cycle right after DONE, so the table runs back-to-back.
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d done",  i), {31'b0, r_done},  32'h1);
         checkOutput($sformatf("vec%0d stall", i), r_stall,          vecs[i].exp_stall);
         checkOutput($sformatf("vec%0d addr",  i), r_addr,           vecs[i].exp_addr);
         checkOutput($sformatf("vec%0d wstrb", i), {28'b0, r_wstrb}, {28'b0, vecs[i].exp_wstrb});
         checkOutput($sformatf("vec%0d we",    i), {31'b0, r_we},    {31'b0, vecs[i].wr});
         checkOutput($sformatf("vec%0d load",  i), r_load,           vecs[i].exp_load);
         checkOutput($sformatf("vec%0d fault", i), {31'b0, r_fault}, 32'h0);
         if (vecs[i].wr) begin
            checkOutput($sformatf("vec%0d wdata", i), r_wdata, vecs[i].exp_wdata);
         end
      end

      // Reset while waiting for a response: the late response must be dropped.
      req_valid      = 1'b1;
      mem_read       = 1'b1;
      funct3         = 3'b010;
      addr           = 32'h0000_0040;
      dbus_req_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstwait req_valid", {31'b0, dbus_req_valid}, 32'h1);
      @(posedge clk);
      #1;
      checkOutput("rstwait in wait stall", {31'b0, stall}, 32'h1);
      checkOutput("rstwait in wait req",   {31'b0, dbus_req_valid}, 32'h0);
      rst            = 1'b1;
      dbus_req_ready = 1'b0;
      @(posedge clk);
      #1;
      rst            = 1'b0;
      req_valid      = 1'b0;
      mem_read       = 1'b0;
      dbus_rsp_valid = 1'b1;
      dbus_rdata     = 32'h5555_5555;
      #1;
      checkOutput("rstwait stall",     {31'b0, stall},          32'h0);
      checkOutput("rstwait load_data", load_data,               32'h0);
      checkOutput("rstwait req",       {31'b0, dbus_req_valid}, 32'h0);
      checkOutput("rstwait addr",      dbus_addr,               32'h0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstwait late load", load_data,     32'h0);
      checkOutput("rstwait late stall", {31'b0, stall}, 32'h0);
      dbus_rsp_valid = 1'b0;
      @(posedge clk);
      #1;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
      req_valid = 1'b1;
      mem_read  = 1'b1;
      funct3    = 3'b010;
      addr      = 32'h0000_0101;
      #1;
      checkOutput("misalign stall",     {31'b0, stall},          32'h0);
      checkOutput("misalign req",       {31'b0, dbus_req_valid}, 32'h0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      mem_read  = 1'b0;
      checkOutput("misalign fault",     {31'b0, misaligned_fault}, 32'h1);
      checkOutput("misalign req after", {31'b0, dbus_req_valid},   32'h0);
      checkOutput("misalign load",      load_data,                 32'h0);
      @(posedge clk);
      #1;
      checkOutput("misalign fault end", {31'b0, misaligned_fault}, 32'h0);
`else
      applyStimulus(mkVec(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hDEADBEEF, 0, 0,
                          32'h0000_0100, 4'b0000, 32'h0, 32'hDEADBEEF, 3));
      checkOutput("misalign lw done",  {31'b0, r_done},  32'h1);
      checkOutput("misalign lw addr",  r_addr,           32'h0000_0100);
      checkOutput("misalign lw load",  r_load,           32'hDEADBEEF);
      checkOutput("misalign lw fault", {31'b0, r_fault}, 32'h0);
      applyStimulus(mkVec(1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h00001234, 32'h0, 0, 0,
                          32'h0000_0000, 4'b1100, 32'h12341234, 32'hDEADBEEF, 3));
      checkOutput("misalign sh wstrb", {28'b0, r_wstrb}, 32'h0000000C);
      checkOutput("misalign sh wdata", r_wdata,          32'h12341234);
      checkOutput("misalign sh stall", r_stall,          32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
